mips_imem_loader: RTL and testbench
===================================

Name: mips_imem_loader

Overview:
- Boot loader for the single-cycle MIPS core; the write-side counterpart to the core's instruction-memory read port.
- Accepts a byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words and writes them to sequential word addresses of instruction RAM.
- Holds the core in reset until the full image is written.

Parameters:
- Data_Width, 32, instruction word width; only 32 is supported.
- AW, 10, instruction RAM word-address width; depth is 2**AW words.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready at a rising edge.
- start  in  1  request a reload; honoured only in DONE or ERR.
- wr_en  out  1  one-cycle instruction RAM write strobe.
- wr_addr  out  AW  word address for the write; increments by 1 per word.
- wr_data  out  Data_Width  assembled instruction word.
- cpu_rst  out  1  reset to the MIPS core; high until the load completes.
- done  out  1  image fully loaded.
- err  out  1  header word count exceeds the RAM depth.

Behaviour:
- Stream format: 2-byte big-endian word count N (high byte first), then N*4 data bytes. The first byte of each word maps to [31:24], the last byte to [7:0].
- States: HDR_HI, HDR_LO, DATA, DONE, ERR.
- Reset (asynchronous, any time, including mid-load):
  - state=HDR_HI, byte index=0, word counter=0.
  - wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, done=0, err=0.
  - Any partially assembled word is discarded.
- in_ready=1 in HDR_HI, HDR_LO and DATA; 0 in DONE and ERR. in_ready is independent of in_valid.
- HDR_HI: on accept, latch N[15:8], go to HDR_LO.
- HDR_LO: on accept, latch N[7:0], then:
  - N==0: go to DONE.
  - N > 2**AW: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - Each accept shifts the byte into the assembly register and increments a 2-bit byte index.
  - On accept of the 4th byte, at the same edge: wr_data <= assembled word, wr_en <= 1. wr_addr holds the current word address during the wr_en cycle.
  - At the edge after the write, wr_addr increments. Write latency is one cycle after the last byte is accepted.
  - If the word just completed is word N, the state goes to DONE at the same edge wr_en rises.
  - Idle cycles (in_valid=0) stall the load without effect.
- wr_en is high for exactly one cycle per word and is never high outside word writes.
- Back-to-back words: with continuous in_valid, one write occurs every 4 cycles.
- cpu_rst is registered: cpu_rst <= (state != DONE) at every edge.
  - It falls one edge after DONE is entered, which is one cycle after the final wr_en, so the last write lands before the core fetches.
  - It rises one edge after leaving DONE.
- done is high in DONE only. err is high in ERR only. ERR holds cpu_rst=1.
- start in DONE or ERR: go to HDR_HI and clear wr_addr, byte index, word counter, done and err; cpu_rst reasserts at the next edge. start is ignored in all other states.
- Word address wrap cannot occur: the maximum N (2**AW) ends at address 2**AW-1.

Test Plan:
- Reset values: assert rst mid-cycle with no clock -> wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, done=0, err=0, in_ready=1.
- Two-word load: continuous bytes 00 02 DE AD BE EF 01 23 45 67 -> wr_en pulses with (addr 0, 0xDEADBEEF) then (addr 1, 0x01234567), 4 cycles apart; done=1 with the second pulse; cpu_rst falls one cycle later; in_ready=0 afterwards.
- Backpressure: same stream with in_valid dropped for 3 random cycles between each byte -> identical writes and data; no extra wr_en pulses.
- N=0: bytes 00 00 -> no wr_en; DONE one cycle after the second byte; cpu_rst falls the next cycle.
- Overflow with AW=4: bytes 00 11 (N=17) -> err=1, in_ready=0, cpu_rst stays 1. start=1 -> err=0, HDR_HI. Stream 00 01 11 22 33 44 -> write at addr 0 of 0x11223344, done=1.
- Reset mid-load: assert rst after 2 data bytes of word 1 -> outputs return to reset values. Reload 00 01 CA FE BA BE -> single write at addr 0 of 0xCAFEBABE.

Source files
------------

// File: rtl/mips_imem_loader_if.sv
// mips_imem_loader_if: connects the boot-image source to the instruction-memory loader.
//   Byte stream : in_data, in_valid (driven by the source), in_ready (driven by the loader)
//   Control     : start (source requests a reload)
//   RAM write   : wr_en, wr_addr, wr_data (loader drives the instruction RAM)
//   Status      : cpu_rst, done, err (loader drives these)
//   Modports    : master = image source / host side, slave = loader side
interface mips_imem_loader_if #(
  parameter int Data_Width = 32,
  parameter int AW         = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  start;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [Data_Width-1:0] wr_data;
  logic                  cpu_rst;
  logic                  done;
  logic                  err;

  modport master (
    output in_data, in_valid, start,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
  );

  modport slave (
    input  in_data, in_valid, start,
    output in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
  );
endinterface

// File: rtl/mips_imem_loader.sv
// mips_imem_loader: boot loader for the single-cycle MIPS core.
// Receives a byte stream (2-byte big-endian word count N, then N*4 bytes),
// assembles big-endian 32-bit words and writes them to consecutive word
// addresses of instruction RAM. The core is held in reset until the image is in.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus.slave in_data/in_valid/in_ready byte stream, start reload request,
//             wr_en/wr_addr/wr_data RAM write port, cpu_rst/done/err status
module mips_imem_loader #(
  parameter int Data_Width = 32,
  parameter int AW         = 10
) (
  input  logic                clk,
  input  logic                rst,
  mips_imem_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  // RAM depth in words, widened so a 16-bit count can be compared against it.
  localparam logic [16:0] Depth = 17'd1 << AW;

  state_t                state_r;
  logic [1:0]            byte_idx_r;
  logic [16:0]           word_cnt_r;
  logic [7:0]            n_hi_r;
  logic [15:0]           n_words_r;
  logic [23:0]           asm_r;       // first three bytes of the word in progress
  logic                  wr_en_r;
  logic [AW-1:0]         wr_addr_r;
  logic [Data_Width-1:0] wr_data_r;
  logic                  cpu_rst_r;
  logic                  done_r;
  logic                  err_r;
  logic                  in_ready_r;
  logic                  accept_s;
  logic [15:0]           n_hdr_s;

  assign accept_s = bus.in_valid && in_ready_r;
  assign n_hdr_s  = {n_hi_r, bus.in_data};

  // Loader state machine, word assembly and RAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= HDR_HI;
      byte_idx_r <= 2'd0;
      word_cnt_r <= 17'd0;
      n_hi_r     <= 8'd0;
      n_words_r  <= 16'd0;
      asm_r      <= 24'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      wr_en_r   <= 1'b0;
      // Follows the state with one edge of delay, so the final write lands
      // before the core leaves reset.
      cpu_rst_r <= (state_r != DONE);
      // Advance the address on the edge after each write strobe.
      if (wr_en_r) begin
        wr_addr_r <= wr_addr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case (state_r)
        HDR_HI: begin
          if (accept_s) begin
            n_hi_r  <= bus.in_data;
            state_r <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept_s) begin
            n_words_r <= n_hdr_s;
            if (n_hdr_s == 16'd0) begin
              state_r    <= DONE;
              done_r     <= 1'b1;
              in_ready_r <= 1'b0;
            end else if ({1'b0, n_hdr_s} > Depth) begin
              state_r    <= ERR;
              err_r      <= 1'b1;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            asm_r      <= {asm_r[15:0], bus.in_data};
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              wr_en_r    <= 1'b1;
              wr_data_r  <= {asm_r, bus.in_data};
              word_cnt_r <= word_cnt_r + 17'd1;
              // Last word of the image: finish on the same edge as the write.
              if (word_cnt_r + 17'd1 == {1'b0, n_words_r}) begin
                state_r    <= DONE;
                done_r     <= 1'b1;
                in_ready_r <= 1'b0;
              end
            end
          end
        end
        DONE, ERR: begin
          if (bus.start) begin
            state_r    <= HDR_HI;
            wr_addr_r  <= '0;
            byte_idx_r <= 2'd0;
            word_cnt_r <= 17'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ERR;
          err_r      <= 1'b1;
          done_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.cpu_rst  = cpu_rst_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_mips_imem_loader.sv
// tb_mips_imem_loader: directed-vector bench for mips_imem_loader (AW=4, 16-word RAM).
// Inputs change 2 time units after a rising edge; outputs are sampled on the falling edge.
module tb_mips_imem_loader;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  int   w_addr[$];
  int   w_data[$];
  int   w_cyc[$];
  int   done_cyc = -1;
  int   fall_cyc = -1;
  logic done_q   = 1'b0;
  logic cpu_rst_q = 1'b1;

  mips_imem_loader_if #(.Data_Width(32), .AW(4)) bus ();

  mips_imem_loader #(.Data_Width(32), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe and the first done-rise / cpu_rst-fall since the last clear.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      w_addr.push_back(int'(bus.wr_addr));
      w_data.push_back(int'(bus.wr_data));
      w_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1 && done_q == 1'b0 && done_cyc < 0) done_cyc = cyc;
    if (bus.cpu_rst === 1'b0 && cpu_rst_q == 1'b1 && fall_cyc < 0) fall_cyc = cyc;
    done_q    = bus.done;
    cpu_rst_q = bus.cpu_rst;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return (i < w_data.size()) ? w_data[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wa(input int i);
    return (i < w_addr.size()) ? w_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wc(input int i);
    return (i < w_cyc.size()) ? w_cyc[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_mon();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    done_cyc = -1;
    fall_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #2;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[], input int gap);
    foreach (s[i]) send_byte(s[i], gap);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    idle(2);
    clear_mon();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},    {31'd0, bus.wr_en},    32'd0);
    chk({tag, "_wr_addr"},  {28'd0, bus.wr_addr},  32'd0);
    chk({tag, "_wr_data"},  bus.wr_data,           32'd0);
    chk({tag, "_cpu_rst"},  {31'd0, bus.cpu_rst},  32'd1);
    chk({tag, "_done"},     {31'd0, bus.done},     32'd0);
    chk({tag, "_err"},      {31'd0, bus.err},      32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic chk_two_word(input string tag, input int last_cyc);
    chk({tag, "_nwr"},   w_data.size(), 32'd2);
    chk({tag, "_a0"},    wa(0), 32'd0);
    chk({tag, "_d0"},    wd(0), 32'hDEAD_BEEF);
    chk({tag, "_a1"},    wa(1), 32'd1);
    chk({tag, "_d1"},    wd(1), 32'h0123_4567);
    chk({tag, "_wlat"},  wc(1), last_cyc);
    chk({tag, "_done_t"}, done_cyc, wc(1));
    chk({tag, "_fall_t"}, fall_cyc, wc(1) + 32'd1);
    chk({tag, "_done"},  {31'd0, bus.done},     32'd1);
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_cpurst"}, {31'd0, bus.cpu_rst}, 32'd0);
  endtask

  initial begin
    logic [7:0] s2[];
    logic [7:0] big[];
    int         t_last;

    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    s2 = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};

    // Reset with no clock running.
    #3 rst = 1'b1;
    #1 chk_reset_vals("rst");
    clk_en = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    clear_mon();

    // Two-word load, continuous bytes: second write 4 cycles after the first.
    send_stream(s2, 0);
    t_last = cyc;
    idle(6);
    chk_two_word("two", t_last);
    chk("two_gap", wc(1) - wc(0), 32'd4);

    // Reload with 3 idle cycles before every byte.
    pulse_start();
    chk("restart_cpurst", {31'd0, bus.cpu_rst}, 32'd1);
    chk("restart_done",   {31'd0, bus.done},    32'd0);
    send_stream(s2, 3);
    t_last = cyc;
    idle(6);
    chk_two_word("bp", t_last);

    // Empty image.
    pulse_start();
    send_stream('{8'h00, 8'h00}, 0);
    t_last = cyc;
    idle(4);
    chk("n0_nwr",    w_data.size(), 32'd0);
    chk("n0_done_t", done_cyc, t_last);
    chk("n0_fall_t", fall_cyc, t_last + 1);
    chk("n0_ready",  {31'd0, bus.in_ready}, 32'd0);

    // N=17 exceeds the 16-word RAM.
    pulse_start();
    send_stream('{8'h00, 8'h11}, 0);
    idle(4);
    chk("ovf_err",    {31'd0, bus.err},      32'd1);
    chk("ovf_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("ovf_cpurst", {31'd0, bus.cpu_rst},  32'd1);
    chk("ovf_done",   {31'd0, bus.done},     32'd0);
    chk("ovf_nwr",    w_data.size(),         32'd0);
    pulse_start();
    chk("ovf_clr_err",   {31'd0, bus.err},      32'd0);
    chk("ovf_clr_ready", {31'd0, bus.in_ready}, 32'd1);
    send_stream('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    idle(4);
    chk("one_nwr",  w_data.size(), 32'd1);
    chk("one_a0",   wa(0), 32'd0);
    chk("one_d0",   wd(0), 32'h1122_3344);
    chk("one_done", {31'd0, bus.done}, 32'd1);

    // N=16 exactly fills the RAM; word i is {i, i+1, i+2, i+3}.
    pulse_start();
    big = new[2 + 64];
    big[0] = 8'h00;
    big[1] = 8'h10;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) big[2 + 4*i + j] = 8'(i + j);
    send_stream(big, 0);
    idle(4);
    chk("full_err",  {31'd0, bus.err},  32'd0);
    chk("full_done", {31'd0, bus.done}, 32'd1);
    chk("full_nwr",  w_data.size(), 32'd16);
    chk("full_a15",  wa(15), 32'd15);
    chk("full_d15",  wd(15), 32'h0F10_1112);
    chk("full_d7",   wd(7),  32'h0708_090A);

    // Reset after two data bytes of the first word, then a fresh load.
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'hAA, 8'hBB}, 0);
    rst = 1'b1;
    #1 chk_reset_vals("mid");
    @(posedge clk); #2;
    rst = 1'b0;
    chk("mid_nwr", w_data.size(), 32'd0);
    clear_mon();
    send_stream('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE}, 0);
    idle(4);
    chk("mid_reload_nwr",  w_data.size(), 32'd1);
    chk("mid_reload_a0",   wa(0), 32'd0);
    chk("mid_reload_d0",   wd(0), 32'hCAFE_BABE);
    chk("mid_reload_done", {31'd0, bus.done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
